// File: rtl/goertzel_tone_detector_if.sv
// Handshake bundle between the Goertzel tone detector and its controller.
//   start/blk_len/coef : block launch and its parameters (blk_len, Q2.16 coef)
//   s_valid/s_data/s_ready : sample stream into the detector
//   busy               : detector is not idle
//   m_valid/m_ready/m_power/m_sat : result handshake, bin power and saturation flag
// The master modport is the controller side, the slave modport the detector.
interface goertzel_tone_detector_if #(
    parameter int DATA_W = 16,
    parameter int PWR_W  = 48
) ();
    logic                     start;
    logic [11:0]              blk_len;
    logic signed [17:0]       coef;
    logic                     s_valid;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_ready;
    logic                     busy;
    logic                     m_valid;
    logic                     m_ready;
    logic [PWR_W-1:0]         m_power;
    logic                     m_sat;

    modport master (
        output start, blk_len, coef, s_valid, s_data, m_ready,
        input  s_ready, busy, m_valid, m_power, m_sat
    );

    modport slave (
        input  start, blk_len, coef, s_valid, s_data, m_ready,
        output s_ready, busy, m_valid, m_power, m_sat
    );
endinterface

// File: rtl/goertzel_tone_detector.sv
// Single-bin Goertzel power detector for notch-filter AC characterisation.
// Runs s = x + coef*s1 - s2 over a block of blk_len samples, then forms the
// bin power s1^2 + s2^2 - coef*s1*s2 with one shared multiplier.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, aborts any block in flight
//   bus  : slave side of goertzel_tone_detector_if (launch, sample stream,
//          result handshake, busy)
module goertzel_tone_detector #(
    parameter int DATA_W    = 16,
    parameter int ST_W      = 32,
    parameter int PWR_W     = 48,
    parameter int PWR_SHIFT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    goertzel_tone_detector_if.slave  bus
);
    localparam int COEF_W = 18;
    localparam int FRAC_W = 16;
    localparam int RC_W   = COEF_W + ST_W;   // full coef*s1 product
    localparam int FB_W   = RC_W - FRAC_W;   // feedback term after the Q2.16 shift
    localparam int SUM_W  = FB_W + 2;        // headroom for x + fb - s2
    localparam int ACC_W  = 2 * ST_W + 4;    // power accumulator

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ACCUM = 3'd1;
    localparam logic [2:0] PWR0  = 3'd2;
    localparam logic [2:0] PWR1  = 3'd3;
    localparam logic [2:0] PWR2  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic signed [SUM_W-1:0] ST_MAX = {{(SUM_W-ST_W+1){1'b0}}, {(ST_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ST_MIN = {{(SUM_W-ST_W+1){1'b1}}, {(ST_W-1){1'b0}}};
    localparam logic [ACC_W-1:0]        PWR_MAX = {{(ACC_W-PWR_W){1'b0}}, {PWR_W{1'b1}}};

    logic [2:0]               state;
    logic [11:0]              len_q;
    logic [11:0]              cnt;
    logic signed [COEF_W-1:0] coef_q;
    logic signed [ST_W-1:0]   s1;
    logic signed [ST_W-1:0]   s2;
    logic                     sat;
    logic signed [ACC_W-1:0]  prod_q;
    logic signed [ACC_W-1:0]  acc;
    logic                     m_valid_q;
    logic [PWR_W-1:0]         m_power_q;
    logic                     m_sat_q;

    // Recurrence datapath: floor(coef*s1 / 2^16) is also the first factor of c.
    logic signed [RC_W-1:0]  rc_full;
    logic signed [FB_W-1:0]  fb;
    logic signed [SUM_W-1:0] s_next;
    logic signed [ST_W-1:0]  s_sat;
    logic                    s_clamp;

    assign rc_full = RC_W'(coef_q) * RC_W'(s1);
    assign fb      = FB_W'(rc_full >>> FRAC_W);
    assign s_next  = SUM_W'(bus.s_data) + SUM_W'(fb) - SUM_W'(s2);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (which would infer a latch).
    always_comb begin
        s_sat   = s_next[ST_W-1:0];
        s_clamp = 1'b0;
        if (s_next > ST_MAX) begin
            s_sat   = ST_MAX[ST_W-1:0];
            s_clamp = 1'b1;
        end else if (s_next < ST_MIN) begin
            s_sat   = ST_MIN[ST_W-1:0];
            s_clamp = 1'b1;
        end
    end

    // Shared power multiplier: operands selected by the power-phase state.
    logic signed [FB_W-1:0]  mul_a;
    logic signed [ST_W-1:0]  mul_b;
    logic signed [ACC_W-1:0] mul_p;

    always_comb begin
        mul_a = fb;
        mul_b = s2;
        case (state)
            PWR0:    begin mul_a = FB_W'(s1); mul_b = s1; end
            PWR1:    begin mul_a = FB_W'(s2); mul_b = s2; end
            default: begin mul_a = fb;        mul_b = s2; end
        endcase
    end

    assign mul_p = ACC_W'(mul_a) * ACC_W'(mul_b);

    // The product is registered, so c only joins the sum in the first DONE
    // cycle; m_valid follows one edge later.
    logic signed [ACC_W-1:0] raw;
    logic [ACC_W-1:0]        raw_shift;
    logic [PWR_W-1:0]        pwr_fmt;
    logic                    pwr_clamp;

    assign raw       = acc - prod_q;
    assign raw_shift = raw >> PWR_SHIFT;

    always_comb begin
        pwr_fmt   = '0;
        pwr_clamp = 1'b0;
        if (!raw[ACC_W-1]) begin
            if (raw_shift > PWR_MAX) begin
                pwr_fmt   = '1;
                pwr_clamp = 1'b1;
            end else begin
                pwr_fmt = raw_shift[PWR_W-1:0];
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            coef_q    <= '0;
            s1        <= '0;
            s2        <= '0;
            sat       <= 1'b0;
            prod_q    <= '0;
            acc       <= '0;
            m_valid_q <= 1'b0;
            m_power_q <= '0;
            m_sat_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.blk_len != 12'd0) begin
                        len_q  <= bus.blk_len;
                        coef_q <= bus.coef;
                        s1     <= '0;
                        s2     <= '0;
                        cnt    <= '0;
                        sat    <= 1'b0;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (bus.s_valid) begin
                        s2  <= s1;
                        s1  <= s_sat;
                        sat <= sat | s_clamp;
                        cnt <= cnt + 12'd1;
                        if (cnt == len_q - 12'd1) begin
                            state <= PWR0;
                        end
                    end
                end
                PWR0: begin
                    prod_q <= mul_p;
                    state  <= PWR1;
                end
                PWR1: begin
                    acc    <= prod_q;
                    prod_q <= mul_p;
                    state  <= PWR2;
                end
                PWR2: begin
                    acc    <= acc + prod_q;
                    prod_q <= mul_p;
                    state  <= DONE;
                end
                DONE: begin
                    if (!m_valid_q) begin
                        m_power_q <= pwr_fmt;
                        m_sat_q   <= sat | pwr_clamp;
                        m_valid_q <= 1'b1;
                    end else if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = (state == ACCUM);
    assign bus.busy    = (state != IDLE);
    assign bus.m_valid = m_valid_q;
    assign bus.m_power = m_power_q;
    assign bus.m_sat   = m_sat_q;
endmodule

// File: tb/tb_goertzel_tone_detector.sv
// Directed bench for goertzel_tone_detector with hand-computed bin powers.
module tb_goertzel_tone_detector;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    goertzel_tone_detector_if #(.DATA_W(16), .PWR_W(48)) bus ();

    goertzel_tone_detector #(
        .DATA_W(16), .ST_W(32), .PWR_W(48), .PWR_SHIFT(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic signed [15:0] vec[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] len, input logic [17:0] c);
        bus.start   = 1'b1;
        bus.blk_len = len;
        bus.coef    = c;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic send(input logic signed [15:0] x);
        bus.s_valid = 1'b1;
        bus.s_data  = x;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.m_valid !== 1'b1 && lat < 2000) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.s_ready, bus.busy, bus.m_valid, bus.m_sat} !== 4'b0000 || bus.m_power !== 48'd0) begin
            tests_failed++;
            $display("FAIL reset outputs: got rdy/busy/vld/sat=%b power=%0d, expected 0000 power=0",
                     {bus.s_ready, bus.busy, bus.m_valid, bus.m_sat}, bus.m_power);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_zero_len();
        do_start(12'd0, 18'h10000);
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_len: got busy=%b s_ready=%b, expected 0 0", bus.busy, bus.s_ready);
        end
    endtask

    task automatic test_basic_bin();
        int lat;
        do_start(12'd2, 18'h00000);
        tests_run++;
        if (bus.s_ready !== 1'b1 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic start: got s_ready=%b busy=%b, expected 1 1", bus.s_ready, bus.busy);
        end
        send(16'sd1000);
        send(16'sd0);
        tests_run++;
        if (bus.s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic s_ready_drop: got %b expected 0", bus.s_ready);
        end
        wait_result(lat);
        tests_run++;
        if (lat != 4) begin
            tests_failed++;
            $display("FAIL basic latency: got %0d cycles expected 4", lat);
        end
        tests_run++;
        if (bus.m_power !== 48'd1000000 || bus.m_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic result: got power=%0d sat=%b expected 1000000 0", bus.m_power, bus.m_sat);
        end
        tests_run++;
        if (dut.s1 !== 32'sd0 || dut.s2 !== 32'sd1000) begin
            tests_failed++;
            $display("FAIL basic state: got s1=%0d s2=%0d expected 0 1000", dut.s1, dut.s2);
        end
        ack();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic release: got busy=%b m_valid=%b expected 0 0", bus.busy, bus.m_valid);
        end
    endtask

    task automatic test_stalled();
        int  lat;
        logic gap_ok = 1'b1;
        do_start(12'd2, 18'h00000);
        send(16'sd1000);
        repeat (5) begin
            if (bus.s_ready !== 1'b1) gap_ok = 1'b0;
            tick();
        end
        send(16'sd0);
        wait_result(lat);
        tests_run++;
        if (!gap_ok || lat != 4 || bus.m_power !== 48'd1000000 || bus.m_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL stalled: got gap_ready=%b lat=%0d power=%0d sat=%b expected 1 4 1000000 0",
                     gap_ok, lat, bus.m_power, bus.m_sat);
        end
        ack();
    endtask

    // Runs the samples in vec as one block and checks power, sat and latency.
    task automatic test_directed(input string name, input logic [17:0] c, input longint exp_pwr);
        int lat;
        do_start(12'(vec.size()), c);
        foreach (vec[i]) send(vec[i]);
        wait_result(lat);
        tests_run++;
        if (lat != 4 || bus.m_power !== 48'(exp_pwr) || bus.m_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: got lat=%0d power=%0d sat=%b expected 4 %0d 0",
                     name, lat, bus.m_power, bus.m_sat, exp_pwr);
        end
        ack();
    endtask

    task automatic test_saturation();
        int lat;
        do_start(12'd1000, 18'h1FFFF);
        repeat (1000) send(16'sd32767);
        wait_result(lat);
        tests_run++;
        if (lat != 4 || bus.m_sat !== 1'b1) begin
            tests_failed++;
            $display("FAIL saturation: got lat=%0d sat=%b expected 4 1", lat, bus.m_sat);
        end
        ack();
    endtask

    // m_ready held high throughout; trailing sample must not be counted.
    task automatic test_back_to_back();
        int lat;
        bus.m_ready = 1'b1;
        do_start(12'd2, 18'h00000);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'sd1000;
        tick();
        bus.s_data  = 16'sd0;
        tick();
        bus.s_data  = 16'sd5000;
        tick();
        bus.s_valid = 1'b0;
        wait_result(lat);
        tests_run++;
        if (lat != 3 || bus.m_power !== 48'd1000000 || bus.m_sat !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b first: got lat=%0d power=%0d sat=%b expected 3 1000000 0",
                     lat, bus.m_power, bus.m_sat);
        end
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b handshake: got busy=%b m_valid=%b expected 0 0", bus.busy, bus.m_valid);
        end
        do_start(12'd1, 18'h00000);
        tests_run++;
        if (bus.s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b restart: got s_ready=%b expected 1", bus.s_ready);
        end
        send(-16'sd7);
        wait_result(lat);
        tests_run++;
        if (bus.m_power !== 48'd49) begin
            tests_failed++;
            $display("FAIL b2b second: got power=%0d expected 49", bus.m_power);
        end
        tick();
        bus.m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int   lat;
        logic hold_ok = 1'b1;
        do_start(12'd2, 18'h00000);
        send(16'sd1000);
        send(16'sd0);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            bus.start   = (i == 3);
            bus.blk_len = 12'd5;
            if (bus.m_valid !== 1'b1 || bus.m_power !== 48'd1000000 || bus.busy !== 1'b1) hold_ok = 1'b0;
            tick();
        end
        bus.start = 1'b0;
        tests_run++;
        if (!hold_ok || bus.m_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure hold: got stable=%b m_valid=%b expected 1 1", hold_ok, bus.m_valid);
        end
        ack();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.m_power !== 48'd1000000) begin
            tests_failed++;
            $display("FAIL backpressure release: got busy=%b s_ready=%b power=%0d expected 0 0 1000000",
                     bus.busy, bus.s_ready, bus.m_power);
        end
    endtask

    task automatic test_reset_abort();
        logic no_valid = 1'b1;
        do_start(12'd8, 18'h10000);
        send(16'sd1);
        send(16'sd2);
        send(16'sd3);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.s_ready, bus.busy, bus.m_valid, bus.m_sat} !== 4'b0000 || bus.m_power !== 48'd0
            || dut.s1 !== 32'sd0) begin
            tests_failed++;
            $display("FAIL abort outputs: got rdy/busy/vld/sat=%b power=%0d s1=%0d expected 0000 0 0",
                     {bus.s_ready, bus.busy, bus.m_valid, bus.m_sat}, bus.m_power, dut.s1);
        end
        #2 rst = 1'b0;
        repeat (10) begin
            tick();
            if (bus.m_valid !== 1'b0 || bus.busy !== 1'b0) no_valid = 1'b0;
        end
        tests_run++;
        if (!no_valid) begin
            tests_failed++;
            $display("FAIL abort quiet: got a result or busy after reset, expected none");
        end
        vec = '{16'sd1000, 16'sd0};
        test_directed("abort_recover", 18'h00000, 64'd1000000);
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.blk_len = '0;
        bus.coef    = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        test_reset();
        test_zero_len();
        test_basic_bin();
        test_stalled();
        vec = '{16'sd100, 16'sd200, 16'sd300};
        test_directed("coef_one", 18'h10000, 64'd190000);
        vec = '{-16'sd3, 16'sd0};
        test_directed("floor_shift", 18'h08000, 64'd10);
        vec = '{16'sd32767, -16'sd32767, 16'sd32767, -16'sd32767, 16'sd32767, -16'sd32767};
        test_directed("nyquist", 18'h20000, 64'd38652346404);
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
